// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: text geometry, clear character, arbiter state
// encoding and the cell address mapping used by every block on the text RAM.
package fb_pkg;

    localparam int COLS = 80;
    localparam int ROWS = 30;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam logic [7:0] CLEAR_CHAR = 8'h20;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // row*80 + col built from two shifts so no multiplier is needed
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
        logic [ADDR_W-1:0] r;
        r = ADDR_W'(row);
        return (r << 6) + (r << 4) + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/fb_cmd_fifo.sv
// Small synchronous FIFO holding host character writes as {address, data}
// until the arbiter finds a RAM cycle the scan path does not need.
module fb_cmd_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fb_access_arbiter.sv
// Shares the single-port text RAM between scan-out fetches (always first),
// the hardware clear-screen sequencer, and queued host character writes.
module fb_access_arbiter #(
    parameter int                 COLS       = fb_pkg::COLS,
    parameter int                 ROWS       = fb_pkg::ROWS,
    parameter int                 ADDR_W     = fb_pkg::ADDR_W,
    parameter int                 DATA_W     = fb_pkg::DATA_W,
    parameter int                 FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0]  CLEAR_CHAR = DATA_W'(fb_pkg::CLEAR_CHAR)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               scan_req,
    input  logic [ADDR_W-1:0]  scan_addr,
    output logic               scan_valid,
    output logic [DATA_W-1:0]  scan_data,
    input  logic               host_valid,
    output logic               host_ready,
    input  logic [6:0]         host_col,
    input  logic [4:0]         host_row,
    input  logic [DATA_W-1:0]  host_data,
    input  logic               clr_req,
    output logic               busy,
    output logic [7:0]         drop_cnt,
    output logic               ram_en,
    output logic               ram_we,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [DATA_W-1:0]  ram_wdata,
    input  logic [DATA_W-1:0]  ram_rdata
);

    import fb_pkg::state_t;
    import fb_pkg::IDLE;
    import fb_pkg::CLEAR;
    import fb_pkg::cell_addr;

    localparam int                 EW        = ADDR_W + DATA_W;
    localparam int                 CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]      DEPTH_L   = CW'(FIFO_DEPTH);
    localparam logic [6:0]         COLS_L    = 7'(COLS);
    localparam logic [4:0]         ROWS_L    = 5'(ROWS);
    localparam logic [ADDR_W-1:0]  LAST_CELL = ADDR_W'(COLS*ROWS - 1);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   clr_ptr;
    logic [ADDR_W-1:0]   clr_ptr_nxt;
    logic                in_range;
    logic                accept;
    logic                fifo_push;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic [EW-1:0]       fifo_head;
    logic                grant_scan;
    logic                grant_clear;
    logic                grant_fifo;
    logic                rd_pend;

    assign host_ready = (fifo_count < DEPTH_L);
    assign in_range   = (host_col < COLS_L) && (host_row < ROWS_L);
    assign accept     = host_valid && host_ready;
    assign fifo_push  = accept && in_range && !fifo_full;
    assign busy       = (state == CLEAR);

    fb_cmd_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (grant_fifo),
        .wdata ({ADDR_W'(cell_addr(host_row, host_col)), host_data}),
        .rdata (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Host writes wait out the whole clear so they are never overwritten by it
    always_comb begin
        grant_scan  = scan_req;
        grant_clear = !scan_req && (state == CLEAR);
        grant_fifo  = !scan_req && (state == IDLE) && !fifo_empty;
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt   = CLEAR;
                    clr_ptr_nxt = '0;
                end
            end
            CLEAR: begin
                if (clr_req) begin
                    clr_ptr_nxt = '0;
                end else if (grant_clear) begin
                    clr_ptr_nxt = clr_ptr + 1'b1;
                    if (clr_ptr == LAST_CELL) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_en <= grant_scan || grant_clear || grant_fifo;
            ram_we <= grant_clear || grant_fifo;
            if (grant_scan) begin
                ram_addr <= scan_addr;
            end else if (grant_clear) begin
                ram_addr  <= clr_ptr;
                ram_wdata <= CLEAR_CHAR;
            end else if (grant_fifo) begin
                ram_addr  <= fifo_head[EW-1:DATA_W];
                ram_wdata <= fifo_head[DATA_W-1:0];
            end
        end
    end

    // RAM data arrives one cycle after the read; register it once more for the pixel pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend    <= 1'b0;
            scan_valid <= 1'b0;
            scan_data  <= '0;
            drop_cnt   <= '0;
        end else begin
            rd_pend    <= ram_en && !ram_we;
            scan_valid <= rd_pend;
            if (rd_pend) scan_data <= ram_rdata;
            if (accept && !in_range && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Scoreboard bench for fb_access_arbiter: stimulus queues expected RAM writes and
// scan fetches, a negedge monitor pops and compares whatever the DUT presents.
module tb_fb_access_arbiter;

    logic        clk;
    logic        rst_n;
    logic        scan_req;
    logic [11:0] scan_addr;
    logic        scan_valid;
    logic [7:0]  scan_data;
    logic        host_valid;
    logic        host_ready;
    logic [6:0]  host_col;
    logic [4:0]  host_row;
    logic [7:0]  host_data;
    logic        clr_req;
    logic        busy;
    logic [7:0]  drop_cnt;
    logic        ram_en;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    logic [19:0] exp_wr[$];
    logic [7:0]  exp_scan[$];
    int          total_checks;
    int          passed_checks;
    int          writes_seen;
    int          scans_seen;

    fb_access_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_req   (scan_req),
        .scan_addr  (scan_addr),
        .scan_valid (scan_valid),
        .scan_data  (scan_data),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_col   (host_col),
        .host_row   (host_row),
        .host_data  (host_data),
        .clr_req    (clr_req),
        .busy       (busy),
        .drop_cnt   (drop_cnt),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Text RAM stand-in: each cell reads back as its low address byte xor 5A
    always @(posedge clk) begin
        if (ram_en && !ram_we) ram_rdata <= ram_addr[7:0] ^ 8'h5A;
    end

    always @(posedge clk) begin
        if (rst_n && scan_req) exp_scan.push_back(scan_addr[7:0] ^ 8'h5A);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual === expected) passed_checks++;
        else $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
    endtask

    always @(negedge clk) begin
        if (rst_n && ram_en && ram_we) begin
            writes_seen++;
            if (exp_wr.size() == 0) checkOutput("unexpected_write", {12'd0, ram_addr, ram_wdata}, 32'hFFFF_FFFF);
            else checkOutput("ram_write", {12'd0, ram_addr, ram_wdata}, {12'd0, exp_wr.pop_front()});
        end
        if (rst_n && scan_valid) begin
            scans_seen++;
            if (exp_scan.size() == 0) checkOutput("unexpected_scan", {24'd0, scan_data}, 32'hFFFF_FFFF);
            else checkOutput("scan_data", {24'd0, scan_data}, {24'd0, exp_scan.pop_front()});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [6:0] col, input logic [4:0] row, input logic [7:0] data,
                                 output logic accepted);
        host_valid = 1'b1;
        host_col   = col;
        host_row   = row;
        host_data  = data;
        accepted   = host_ready;
        if (accepted && col < 7'd80 && row < 5'd30) exp_wr.push_back({12'(row * 80 + col), data});
        tick(1);
        host_valid = 1'b0;
    endtask

    initial begin
        logic acc;
        logic rdy;
        int   w0;
        int   s0;
        int   c;

        total_checks = 0; passed_checks = 0; writes_seen = 0; scans_seen = 0;
        rst_n = 1'b0; scan_req = 1'b1; scan_addr = 12'd7;
        host_valid = 1'b0; host_col = '0; host_row = '0; host_data = '0;
        clr_req = 1'b0; ram_rdata = '0;

        tick(3);
        checkOutput("reset_ram", 32'({ram_en, ram_we, ram_addr, ram_wdata}), 32'd0);
        checkOutput("reset_misc", 32'({scan_valid, scan_data, busy, drop_cnt}), 32'd0);
        checkOutput("reset_host_ready", 32'(host_ready), 32'd1);
        rst_n = 1'b1;
        tick(1);
        checkOutput("first_scan_after_reset", 32'({ram_en, ram_we, ram_addr}), 32'({1'b1, 1'b0, 12'd7}));
        scan_req = 1'b0;
        tick(4);

        applyStimulus(7'd5, 5'd2, 8'h41, acc);
        checkOutput("single_write_not_early", 32'(ram_we), 32'd0);
        tick(1);
        checkOutput("single_write", 32'({ram_we, ram_addr, ram_wdata}), 32'({1'b1, 12'd165, 8'h41}));
        tick(1);
        checkOutput("single_write_one_cycle", 32'(ram_we), 32'd0);
        tick(3);

        w0 = writes_seen; s0 = scans_seen;
        for (int i = 0; i < 10; i++) begin
            scan_req  = 1'b1;
            scan_addr = 12'(100 + i);
            if (i < 5) begin
                host_valid = 1'b1; host_col = 7'(i); host_row = 5'd3; host_data = 8'(8'h30 + i);
                rdy = host_ready;
                checkOutput("burst_host_ready", 32'(rdy), (i < 4) ? 32'd1 : 32'd0);
                if (rdy) exp_wr.push_back({12'(3 * 80 + i), host_data});
            end else begin
                host_valid = 1'b0;
            end
            tick(1);
            if (i == 1) checkOutput("scan_valid_not_early", 32'(scan_valid), 32'd0);
            if (i == 2) checkOutput("scan_valid_latency3", 32'(scan_valid), 32'd1);
        end
        scan_req = 1'b0; host_valid = 1'b0;
        checkOutput("no_writes_during_scan", writes_seen - w0, 32'd0);
        for (int j = 0; j < 4; j++) begin
            tick(1);
            checkOutput("drain_write_back_to_back", 32'(ram_we), 32'd1);
        end
        tick(1);
        checkOutput("drain_done", 32'(ram_we), 32'd0);
        checkOutput("drain_write_count", writes_seen - w0, 32'd4);
        checkOutput("scan_stream_length", scans_seen - s0, 32'd10);

        w0 = writes_seen;
        applyStimulus(7'd80, 5'd0, 8'h99, acc);
        tick(2);
        checkOutput("drop_col80", 32'(drop_cnt), 32'd1);
        applyStimulus(7'd0, 5'd30, 8'h99, acc);
        tick(2);
        checkOutput("drop_row30", 32'(drop_cnt), 32'd2);
        checkOutput("no_write_for_drops", writes_seen - w0, 32'd0);
        for (int k = 0; k < 256; k++) applyStimulus(7'd80, 5'd0, 8'h99, acc);
        tick(1);
        checkOutput("drop_saturates", 32'(drop_cnt), 32'd255);
        applyStimulus(7'd79, 5'd29, 8'h7E, acc);
        tick(3);
        checkOutput("last_cell_write", writes_seen - w0, 32'd1);

        w0 = writes_seen;
        clr_req = 1'b1;
        for (int k = 0; k < 2400; k++) exp_wr.push_back({12'(k), 8'h20});
        tick(1);
        clr_req = 1'b0;
        checkOutput("clear_busy_rises", 32'({busy, ram_we}), 32'b10);
        tick(1);
        checkOutput("clear_first_write", 32'({ram_we, ram_addr, ram_wdata}), 32'({1'b1, 12'd0, 8'h20}));
        c = 0;
        while (c < 4000 && busy) begin
            scan_req  = (c % 8 == 7);
            scan_addr = 12'(c);
            if (c == 500) begin
                host_valid = 1'b1; host_col = 7'd10; host_row = 5'd1; host_data = 8'h55;
                if (host_ready) exp_wr.push_back({12'd90, 8'h55});
            end else begin
                host_valid = 1'b0;
            end
            tick(1);
            c++;
        end
        scan_req = 1'b0; host_valid = 1'b0;
        checkOutput("clear_finished", 32'(busy), 32'd0);
        checkOutput("busy_drops_on_2399", 32'({ram_we, ram_addr}), 32'({1'b1, 12'd2399}));
        tick(10);
        checkOutput("clear_total_writes", writes_seen - w0, 32'd2401);
        checkOutput("write_queue_drained", exp_wr.size(), 32'd0);
        checkOutput("scan_queue_drained", exp_scan.size(), 32'd0);

        w0 = writes_seen;
        clr_req = 1'b1;
        for (int k = 0; k < 1000; k++) exp_wr.push_back({12'(k), 8'h20});
        tick(1);
        clr_req = 1'b0;
        c = 0;
        while (c < 1500 && !(ram_we && ram_addr == 12'd999)) begin
            if (c == 20) begin
                host_valid = 1'b1; host_col = 7'd2; host_row = 5'd0; host_data = 8'h11;
                if (host_ready) exp_wr.push_back({12'd2, 8'h11});
            end else begin
                host_valid = 1'b0;
            end
            tick(1);
            c++;
        end
        host_valid = 1'b0;
        checkOutput("reached_write_1000", 32'({ram_we, ram_addr}), 32'({1'b1, 12'd999}));
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_clear", 32'({busy, ram_en, ram_we, host_ready, drop_cnt}), 32'({4'b0001, 8'd0}));
        checkOutput("host_write_abandoned", exp_wr.size(), 32'd1);
        exp_wr.delete();
        exp_scan.delete();
        tick(1);
        rst_n = 1'b1;
        tick(30);
        checkOutput("writes_before_reset", writes_seen - w0, 32'd1000);
        checkOutput("idle_after_reset", 32'({busy, ram_en}), 32'd0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/fb_access_arbiter.md
# fb_access_arbiter

Arbitrates the single-port text RAM behind the VGA text framebuffer between the scan-out path and a host character-write port, and sequences a hardware clear-screen. Scan-out fetches have absolute priority, so display timing is never disturbed. Host writes are queued in a small FIFO and retired only on RAM cycles the scan path leaves free. The block sits between the framebuffer pixel pipeline and the UART/command decoder.

## Interface
Parameters:
- COLS, 80, text columns (640 / 8-pixel glyph width)
- ROWS, 30, text rows (480 / 16-pixel glyph height)
- ADDR_W, 12, text RAM address width
- DATA_W, 8, character code width
- FIFO_DEPTH, 4, host write queue entries (power of two)
- CLEAR_CHAR, 8'h20, code written by clear

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- scan_req  in  1  framebuffer needs a character fetch this cycle
- scan_addr  in  ADDR_W  cell address to fetch
- scan_valid  out  1  fetched character valid
- scan_data  out  DATA_W  fetched character
- host_valid  in  1  host write request
- host_ready  out  1  FIFO can accept; equals (count < FIFO_DEPTH), combinational
- host_col  in  7  target column
- host_row  in  5  target row
- host_data  in  DATA_W  character code
- clr_req  in  1  single-cycle clear-screen request
- busy  out  1  clear in progress
- drop_cnt  out  8  saturating count of rejected out-of-range host writes
- ram_en, ram_we  out  1 each  RAM enable / write enable, registered
- ram_addr  out  ADDR_W  RAM address, registered
- ram_wdata  out  DATA_W  RAM write data, registered
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_en

## Operation
- States: IDLE, CLEAR. Reset → IDLE.
- Host push on host_valid && host_ready.
  - col >= COLS or row >= ROWS: entry is not stored; drop_cnt increments, saturating at 255.
  - Otherwise store {addr = row*COLS + col, data}. Address is computed as (row<<6)+(row<<4)+col for COLS = 80.
- Per-cycle grant, in priority order:
  1. scan_req: read at scan_addr.
  2. state CLEAR: write CLEAR_CHAR at clr_ptr, then clr_ptr++.
  3. FIFO non-empty: pop the head and write it.
  4. None: ram_en = 0.
- CLEAR holds queued host writes; the FIFO still accepts entries while clearing. Host writes therefore always land after the clear.
- IDLE → CLEAR on clr_req, clr_ptr = 0.
- clr_req while in CLEAR restarts clr_ptr at 0.
- CLEAR → IDLE on the same edge that issues the write to COLS*ROWS-1.
- busy = (state == CLEAR).
- Simultaneous push and pop on a non-full FIFO are both honoured, and count is unchanged. The head is still popped when full, but host_ready stays 0 that cycle.

## Timing
- Reset values: ram_en = ram_we = 0; ram_addr = ram_wdata = 0; scan_valid = 0; scan_data = 0; busy = 0; drop_cnt = 0; FIFO empty, so host_ready = 1.
- Asserting rst_n low mid-clear or with a non-empty FIFO abandons all pending work. No RAM write follows deassertion until a new request arrives.
- Scan read, with scan_req sampled at edge N:
  - edge N+1: ram_en = 1, ram_we = 0, ram_addr = scan_addr.
  - edge N+3: scan_valid = 1 and scan_data = ram_rdata, held one cycle.
  - Fixed latency 3, back-to-back every cycle.
- Host write, handshake at edge N:
  - Earliest ram_we = 1 at edge N+2.
  - Delayed by every cycle with scan_req = 1 or state CLEAR.
- Clear, clr_req at edge N:
  - busy = 1 from edge N+1.
  - First clear write at N+2 if no scan_req.
  - Takes exactly COLS*ROWS non-scan cycles.

## Structure
- Shared package fb_pkg holds:
  - COLS, ROWS, ADDR_W, DATA_W, CLEAR_CHAR;
  - the state encoding (IDLE = 1'b0, CLEAR = 1'b1);
  - the address function row*COLS + col.
- The framebuffer and the command decoder reuse fb_pkg.
- One sub-module: fb_cmd_fifo, a synchronous FIFO of {ADDR_W, DATA_W} entries with count, push, pop, full and empty.

## Test plan
- Reset with scan_req = 1: all outputs at the reset values above, host_ready = 1. First ram_en = 1 appears one edge after rst_n rises.
- Single write col = 5, row = 2, data = 8'h41, no scan: two edges after the handshake, ram_we = 1, ram_addr = 165, ram_wdata = 8'h41 for one cycle.
- Scan priority:
  - Stimulus: hold scan_req 10 cycles, push 5 writes.
  - host_ready = 0 after 4 pushes and no writes during the scan burst.
  - After release, 4 consecutive writes in push order.
  - scan_valid stream: 10 cycles, starting 3 edges after the first scan_req.
- Out-of-range push col = 80, row = 0: no RAM write, drop_cnt = 1. 256 such pushes leave drop_cnt at 255.
- Clear with scan_req every 8th cycle:
  - Exactly 2400 writes of 8'h20 to addresses 0..2399, in order.
  - busy stays high until the write to 2399.
  - A host write queued mid-clear appears after address 2399.
- Reset mid-clear at write 1000: busy = 0 immediately; no RAM writes after reset release.
